// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The winner choice is pure combinational logic, so it lives here as a function.
package mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
  } mem_req_t;

  // A tie under round-robin goes to the port that was not granted last.
  function automatic logic pick_winner(input logic pend0, input logic pend1,
                                       input logic last_grant, input logic fixed_prio);
    logic w;
    w = ARB_P0;
    if (pend1 && !pend0)
      w = ARB_P1;
    else if (pend0 && pend1 && !fixed_prio && (last_grant == ARB_P0))
      w = ARB_P1;
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// Per-port request slot: latches one request, holds busy until the arbiter completes it,
// then pulses done for one cycle. Requests arriving while busy are dropped, not queued.
module mem_arb_slot
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rstrb,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        complete,
  input  logic [31:0] mem_rdata,
  output mem_req_t    req,
  output logic        pending,
  output logic [31:0] rdata,
  output logic        done
);

  always_ff @(posedge clk) begin
    if (reset) begin
      req     <= '0;
      pending <= 1'b0;
      rdata   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (complete) begin
        pending <= 1'b0;
        done    <= 1'b1;
        if (req.rstrb)
          rdata <= mem_rdata;
      end else if ((rstrb || (|wmask)) && !pending) begin
        req.addr  <= addr;
        req.wdata <= wdata;
        req.wmask <= wmask;
        req.rstrb <= rstrb;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two masters onto one single-ported memory: strobe cycle then data cycle,
// 3-cycle uncontended latency, one access per 2 cycles; a losing port simply stays busy.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] p0_addr,
  input  logic        p0_rstrb,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  output logic [31:0] p0_rdata,
  output logic        p0_busy,
  output logic        p0_done,
  input  logic [31:0] p1_addr,
  input  logic        p1_rstrb,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  output logic [31:0] p1_rdata,
  output logic        p1_busy,
  output logic        p1_done,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam logic FIXED = (FIXED_PRIO != 0);

  arb_state_t state_q, state_d;
  logic       win_q, win_d;
  logic       last_grant_q, last_grant_d;
  logic       pend0, pend1;
  logic       complete0, complete1;
  mem_req_t   req0, req1, sel;

  mem_arb_slot u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .addr      (p0_addr),
    .rstrb     (p0_rstrb),
    .wdata     (p0_wdata),
    .wmask     (p0_wmask),
    .complete  (complete0),
    .mem_rdata (mem_rdata),
    .req       (req0),
    .pending   (pend0),
    .rdata     (p0_rdata),
    .done      (p0_done)
  );

  mem_arb_slot u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .addr      (p1_addr),
    .rstrb     (p1_rstrb),
    .wdata     (p1_wdata),
    .wmask     (p1_wmask),
    .complete  (complete1),
    .mem_rdata (mem_rdata),
    .req       (req1),
    .pending   (pend1),
    .rdata     (p1_rdata),
    .done      (p1_done)
  );

  assign p0_busy = pend0;
  assign p1_busy = pend1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      win_q        <= ARB_P0;
      last_grant_q <= ARB_P1;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    last_grant_d = last_grant_q;
    complete0    = 1'b0;
    complete1    = 1'b0;
    sel          = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    mem_rstrb    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pend0 || pend1) begin
          win_d        = pick_winner(pend0, pend1, last_grant_q, FIXED);
          last_grant_d = win_d;
          sel          = (win_d == ARB_P1) ? req1 : req0;
          mem_addr     = sel.addr;
          mem_wdata    = sel.wdata;
          mem_wmask    = sel.wmask;
          mem_rstrb    = sel.rstrb;
          state_d      = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        // Address stays on the bus while memory returns the read word.
        sel       = (win_q == ARB_P1) ? req1 : req0;
        mem_addr  = sel.addr;
        complete0 = (win_q == ARB_P0);
        complete1 = (win_q == ARB_P1);
        state_d   = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      mem_rstrb = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, scoreboard queues of expected completions,
// and a fixed-priority instance run alongside the round-robin one.
module tb_mem_arbiter;

  logic        clk, reset;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_rstrb, p1_rstrb;
  logic [3:0]  p0_wmask, p1_wmask;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        p0_busy, p1_busy, p0_done, p1_done, mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_p0_busy, fp_p1_busy, fp_p0_done, fp_p1_done, fp_mem_rstrb;
  logic [3:0]  fp_mem_wmask;

  logic [31:0] mem [0:255];
  logic        mem_clear;
  int          cyc = 0;
  int          total_cnt = 0;
  int          pass_cnt = 0;

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    int          cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  mem_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_rdata(p0_rdata), .p0_busy(p0_busy), .p0_done(p0_done),
    .p1_addr(p1_addr), .p1_rstrb(p1_rstrb), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_rdata(p1_rdata), .p1_busy(p1_busy), .p1_done(p1_done),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_rdata(fp_p0_rdata), .p0_busy(fp_p0_busy), .p0_done(fp_p0_done),
    .p1_addr(p1_addr), .p1_rstrb(p1_rstrb), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_rdata(fp_p1_rdata), .p1_busy(fp_p1_busy), .p1_done(fp_p1_done),
    .mem_addr(fp_mem_addr), .mem_rstrb(fp_mem_rstrb), .mem_wdata(fp_mem_wdata),
    .mem_wmask(fp_mem_wmask), .mem_rdata(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: read word registered one cycle after the strobe, byte writes land at the same edge.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[100] = 32'h04030201;
    end else begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit port, output bit ok);
    int n = 0;
    while (((port ? p1_done : p0_done) !== 1'b1) && n < 12) begin
      tick();
      n++;
    end
    ok = ((port ? p1_done : p0_done) === 1'b1);
  endtask

  task automatic clear_reqs;
    p0_rstrb = 1'b0; p0_wmask = 4'h0;
    p1_rstrb = 1'b0; p1_wmask = 4'h0;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    mem_clear = 1'b1;
    reset = 1'b1;
    p0_addr = 32'h190; p0_rstrb = 1'b1; p0_wdata = '0; p0_wmask = 4'h0;
    p1_addr = 32'h320; p1_rstrb = 1'b0; p1_wdata = 32'h12345678; p1_wmask = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if ({p0_rdata, p1_rdata, p0_busy, p1_busy, p0_done, p1_done,
           mem_addr, mem_rstrb, mem_wdata, mem_wmask} !== '0)
        $display("FAIL reset_outputs: got p0_busy=%b p1_busy=%b mem_addr=%h mem_rstrb=%b mem_wmask=%b expected all 0",
                 p0_busy, p1_busy, mem_addr, mem_rstrb, mem_wmask);
      else pass_cnt++;
    end
    reset = 1'b0;
    mem_clear = 1'b0;
    clear_reqs();
    tick();
    total_cnt++;
    if ({p0_busy, p1_busy, mem_rstrb, mem_wmask} !== '0)
      $display("FAIL reset_release: got busy=%b%b rstrb=%b wmask=%b expected 0",
               p0_busy, p1_busy, mem_rstrb, mem_wmask);
    else pass_cnt++;
  endtask

  task automatic test_single_read;
    bit ok; exp_t e;
    p0_addr = 32'h190; p0_rstrb = 1'b1;
    q0.push_back('{32'h04030201, 1'b1, cyc + 3});
    tick();
    clear_reqs();
    total_cnt++;
    if (mem_rstrb !== 1'b1 || mem_addr !== 32'h190 || p0_busy !== 1'b1)
      $display("FAIL read_strobe: got rstrb=%b addr=%h busy=%b expected 1/00000190/1", mem_rstrb, mem_addr, p0_busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (mem_rstrb !== 1'b0 || mem_addr !== 32'h190 || p0_busy !== 1'b1)
      $display("FAIL read_access: got rstrb=%b addr=%h busy=%b expected 0/00000190/1", mem_rstrb, mem_addr, p0_busy);
    else pass_cnt++;
    wait_done(1'b0, ok);
    total_cnt++;
    if (!ok) $display("FAIL read_done_timeout: got no p0_done expected one");
    else begin
      pass_cnt++;
      e = q0.pop_front();
      total_cnt++;
      if (cyc !== e.cyc || p0_rdata !== e.rdata || p0_busy !== 1'b0)
        $display("FAIL read_result: got cyc=%0d rdata=%h busy=%b expected cyc=%0d rdata=%h busy=0",
                 cyc, p0_rdata, p0_busy, e.cyc, e.rdata);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (p0_done !== 1'b0 || p0_rdata !== 32'h04030201)
      $display("FAIL done_pulse_hold: got done=%b rdata=%h expected 0/04030201", p0_done, p0_rdata);
    else pass_cnt++;
  endtask

  task automatic test_byte_write;
    bit ok; exp_t e;
    p1_addr = 32'h321; p1_wdata = 32'h0000AB00; p1_wmask = 4'b0010;
    q1.push_back('{32'h0, 1'b0, cyc + 3});
    tick();
    clear_reqs();
    total_cnt++;
    if (mem_wmask !== 4'b0010 || mem_wdata !== 32'h0000AB00 || mem_addr !== 32'h321 || mem_rstrb !== 1'b0)
      $display("FAIL write_strobe: got wmask=%b wdata=%h addr=%h rstrb=%b expected 0010/0000ab00/00000321/0",
               mem_wmask, mem_wdata, mem_addr, mem_rstrb);
    else pass_cnt++;
    wait_done(1'b1, ok);
    total_cnt++;
    if (!ok || cyc !== q1[0].cyc)
      $display("FAIL write_done: got ok=%b cyc=%0d expected done at cyc=%0d", ok, cyc, q1[0].cyc);
    else pass_cnt++;
    void'(q1.pop_front());
    p1_addr = 32'h320; p1_rstrb = 1'b1;
    q1.push_back('{32'h0000AB00, 1'b1, cyc + 3});
    tick();
    clear_reqs();
    wait_done(1'b1, ok);
    total_cnt++;
    if (!ok) $display("FAIL readback_timeout: got no p1_done expected one");
    else begin
      pass_cnt++;
      e = q1.pop_front();
      total_cnt++;
      if (cyc !== e.cyc || p1_rdata !== e.rdata)
        $display("FAIL readback: got cyc=%0d rdata=%h expected cyc=%0d rdata=%h", cyc, p1_rdata, e.cyc, e.rdata);
      else pass_cnt++;
    end
  endtask

  task automatic test_round_robin;
    bit ok; exp_t e;
    pulse_reset();
    // First tie after reset: port 0, then port 1 straight out of the done cycle.
    p0_addr = 32'h190; p0_rstrb = 1'b1;
    p1_addr = 32'h320; p1_rstrb = 1'b1;
    q0.push_back('{32'h04030201, 1'b1, cyc + 3});
    q1.push_back('{32'h0000AB00, 1'b1, cyc + 5});
    tick();
    clear_reqs();
    total_cnt++;
    if (mem_rstrb !== 1'b1 || mem_addr !== 32'h190)
      $display("FAIL rr_first_grant: got rstrb=%b addr=%h expected 1/00000190", mem_rstrb, mem_addr);
    else pass_cnt++;
    wait_done(1'b0, ok);
    e = q0.pop_front();
    total_cnt++;
    if (!ok || cyc !== e.cyc || p0_rdata !== e.rdata || mem_rstrb !== 1'b1 || mem_addr !== 32'h320)
      $display("FAIL rr_p0_then_p1: got ok=%b cyc=%0d rdata=%h rstrb=%b addr=%h expected cyc=%0d rdata=%h rstrb=1 addr=00000320",
               ok, cyc, p0_rdata, mem_rstrb, mem_addr, e.cyc, e.rdata);
    else pass_cnt++;
    wait_done(1'b1, ok);
    e = q1.pop_front();
    total_cnt++;
    if (!ok || cyc !== e.cyc || p1_rdata !== e.rdata)
      $display("FAIL rr_p1_done: got ok=%b cyc=%0d rdata=%h expected cyc=%0d rdata=%h", ok, cyc, p1_rdata, e.cyc, e.rdata);
    else pass_cnt++;
    // Port 0 alone, so the next tie must go to port 1.
    p0_rstrb = 1'b1;
    q0.push_back('{32'h04030201, 1'b1, cyc + 3});
    tick();
    clear_reqs();
    wait_done(1'b0, ok);
    e = q0.pop_front();
    tick();
    p0_rstrb = 1'b1; p1_rstrb = 1'b1;
    q1.push_back('{32'h0000AB00, 1'b1, cyc + 3});
    q0.push_back('{32'h04030201, 1'b1, cyc + 5});
    tick();
    clear_reqs();
    total_cnt++;
    if (mem_rstrb !== 1'b1 || mem_addr !== 32'h320)
      $display("FAIL rr_alternate: got rstrb=%b addr=%h expected 1/00000320", mem_rstrb, mem_addr);
    else pass_cnt++;
    wait_done(1'b1, ok);
    e = q1.pop_front();
    total_cnt++;
    if (!ok || cyc !== e.cyc) $display("FAIL rr_alt_p1_done: got ok=%b cyc=%0d expected cyc=%0d", ok, cyc, e.cyc);
    else pass_cnt++;
    wait_done(1'b0, ok);
    e = q0.pop_front();
    total_cnt++;
    if (!ok || cyc !== e.cyc) $display("FAIL rr_alt_p0_done: got ok=%b cyc=%0d expected cyc=%0d", ok, cyc, e.cyc);
    else pass_cnt++;
  endtask

  task automatic test_fixed_prio;
    bit ok; int t;
    pulse_reset();
    p0_addr = 32'h190; p1_addr = 32'h320;
    p0_rstrb = 1'b1;
    tick();
    clear_reqs();
    wait_done(1'b0, ok);
    tick();
    // Last grant was port 0: round-robin picks port 1, fixed priority still picks port 0.
    p0_rstrb = 1'b1; p1_rstrb = 1'b1;
    t = cyc;
    tick();
    clear_reqs();
    total_cnt++;
    if (fp_mem_rstrb !== 1'b1 || fp_mem_addr !== 32'h190 || mem_addr !== 32'h320)
      $display("FAIL fixed_grant: got fp_rstrb=%b fp_addr=%h rr_addr=%h expected 1/00000190/00000320",
               fp_mem_rstrb, fp_mem_addr, mem_addr);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (fp_p0_done === 1'b1) begin
        total_cnt++;
        if (cyc !== t + 3) $display("FAIL fixed_p0_done: got cyc=%0d expected cyc=%0d", cyc, t + 3);
        else pass_cnt++;
      end
      if (fp_p1_done === 1'b1) begin
        total_cnt++;
        if (cyc !== t + 5) $display("FAIL fixed_p1_done: got cyc=%0d expected cyc=%0d", cyc, t + 5);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    bit ok; exp_t e;
    p0_addr = 32'h320; p0_rstrb = 1'b1;
    q0.push_back('{32'h0000AB00, 1'b1, cyc + 3});
    tick();
    clear_reqs();
    wait_done(1'b0, ok);
    e = q0.pop_front();
    total_cnt++;
    if (!ok || cyc !== e.cyc || p0_rdata !== e.rdata)
      $display("FAIL b2b_first: got ok=%b cyc=%0d rdata=%h expected cyc=%0d rdata=%h", ok, cyc, p0_rdata, e.cyc, e.rdata);
    else pass_cnt++;
    // Re-request in the done cycle: combined read + byte write returns the old word.
    p0_addr = 32'h190; p0_rstrb = 1'b1; p0_wmask = 4'b0001; p0_wdata = 32'h000000AA;
    q0.push_back('{32'h04030201, 1'b1, cyc + 3});
    tick();
    clear_reqs();
    total_cnt++;
    if (mem_rstrb !== 1'b1 || mem_wmask !== 4'b0001 || mem_addr !== 32'h190)
      $display("FAIL b2b_combined_strobe: got rstrb=%b wmask=%b addr=%h expected 1/0001/00000190", mem_rstrb, mem_wmask, mem_addr);
    else pass_cnt++;
    wait_done(1'b0, ok);
    e = q0.pop_front();
    total_cnt++;
    if (!ok || cyc !== e.cyc || p0_rdata !== e.rdata)
      $display("FAIL b2b_combined: got ok=%b cyc=%0d rdata=%h expected cyc=%0d rdata=%h", ok, cyc, p0_rdata, e.cyc, e.rdata);
    else pass_cnt++;
    p0_rstrb = 1'b1;
    q0.push_back('{32'h040302AA, 1'b1, cyc + 3});
    tick();
    clear_reqs();
    wait_done(1'b0, ok);
    e = q0.pop_front();
    total_cnt++;
    if (!ok || cyc !== e.cyc || p0_rdata !== e.rdata)
      $display("FAIL b2b_readback: got ok=%b cyc=%0d rdata=%h expected cyc=%0d rdata=%h", ok, cyc, p0_rdata, e.cyc, e.rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_access;
    pulse_reset();
    tick();
    total_cnt++;
    if (p0_rdata !== 32'h0) $display("FAIL rdata_after_reset: got %h expected 00000000", p0_rdata);
    else pass_cnt++;
    p0_addr = 32'h190; p0_rstrb = 1'b1;
    tick();
    clear_reqs();
    tick();
    total_cnt++;
    if (mem_rstrb !== 1'b0 || p0_busy !== 1'b1)
      $display("FAIL mid_access_state: got rstrb=%b busy=%b expected 0/1", mem_rstrb, p0_busy);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (p0_done !== 1'b0 || p0_busy !== 1'b0 || mem_rstrb !== 1'b0 || p0_rdata !== 32'h0)
        $display("FAIL aborted_access: got done=%b busy=%b rstrb=%b rdata=%h expected 0/0/0/00000000",
                 p0_done, p0_busy, mem_rstrb, p0_rdata);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_clear = 1'b1;
    p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
    clear_reqs();
    test_reset();
    test_single_read();
    test_byte_write();
    test_round_robin();
    test_fixed_prio();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
